// File: rtl/lvds_rx_align_if.sv
// rtl/lvds_rx_align_if.sv - control, lane data and status bundle for the LVDS receive aligner
interface lvds_rx_align_if #(
   parameter int CHANNELS    = 4,
   parameter int SERI_FACTOR = 10
);
   logic                            idelayCtrl_rdy;
   logic                            start;
   logic [CHANNELS*SERI_FACTOR-1:0] rx_data;
   logic [CHANNELS-1:0]             tap_load;
   logic [CHANNELS*5-1:0]           tap_value;
   logic [CHANNELS-1:0]             bitslip;
   logic [CHANNELS-1:0]             ch_aligned;
   logic                            busy;
   logic                            align_done;
   logic                            align_fail;
`ifdef LVDS_RX_ALIGN_EYE_STATUS_EN
   logic [CHANNELS*6-1:0]           eye_width;
`endif

   // aligner side
   modport slave (
      input  idelayCtrl_rdy, start, rx_data,
      output tap_load, tap_value, bitslip, ch_aligned, busy, align_done, align_fail
`ifdef LVDS_RX_ALIGN_EYE_STATUS_EN
      , output eye_width
`endif
   );

   // controller / serdes side
   modport master (
      output idelayCtrl_rdy, start, rx_data,
      input  tap_load, tap_value, bitslip, ch_aligned, busy, align_done, align_fail
`ifdef LVDS_RX_ALIGN_EYE_STATUS_EN
      , input eye_width
`endif
   );
endinterface

// File: rtl/lvds_rx_align.sv
// rtl/lvds_rx_align.sv - per-lane IDELAY eye sweep, centring and bitslip word alignment; optional eye_width under LVDS_RX_ALIGN_EYE_STATUS_EN
module lvds_rx_align #(
   parameter int                     CHANNELS      = 4,
   parameter int                     SERI_FACTOR   = 10,
   parameter logic [SERI_FACTOR-1:0] TRAIN_PATTERN = SERI_FACTOR'(10'h3E0),
   parameter int                     SETTLE_CYCLES = 16,
   parameter int                     SAMPLE_CYCLES = 8,
   parameter int                     MIN_EYE       = 4
) (
   input  logic               rx_clkdiv,
   input  logic               reset,
   lvds_rx_align_if.slave     bus
);

   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_WAIT_RDY  = 4'd1;
   localparam logic [3:0] S_SET_TAP   = 4'd2;
   localparam logic [3:0] S_SETTLE    = 4'd3;
   localparam logic [3:0] S_SAMPLE    = 4'd4;
   localparam logic [3:0] S_EVAL      = 4'd5;
   localparam logic [3:0] S_CENTER    = 4'd6;
   localparam logic [3:0] S_SLIP      = 4'd7;
   localparam logic [3:0] S_SLIP_WAIT = 4'd8;
   localparam logic [3:0] S_CHECK     = 4'd9;
   localparam logic [3:0] S_NEXT_CH   = 4'd10;
   localparam logic [3:0] S_DONE      = 4'd11;
   localparam logic [3:0] S_FAIL      = 4'd12;

   logic [3:0]             state;
   logic [CH_W-1:0]        ch;
   logic [4:0]             tap;
   logic [7:0]             cnt;
   logic [SERI_FACTOR-1:0] first_word;
   logic                   stable;
   logic                   centred;
   logic [4:0]             cur_start;
   logic [5:0]             cur_len;
   logic [4:0]             best_start;
   logic [5:0]             best_len;
   logic [3:0]             check_cnt;

   logic [CHANNELS-1:0]    tap_load_r;
   logic [CHANNELS*5-1:0]  tap_value_r;
   logic [CHANNELS-1:0]    bitslip_r;
   logic [CHANNELS-1:0]    ch_aligned_r;
   logic                   busy_r;
   logic                   align_done_r;
   logic                   align_fail_r;
`ifdef LVDS_RX_ALIGN_EYE_STATUS_EN
   logic [CHANNELS*6-1:0]  eye_width_r;
`endif

   logic [SERI_FACTOR-1:0] lane_word;
   logic [5:0]             run_len;
   logic [4:0]             run_start;
   logic [5:0]             best_len_n;
   logic [4:0]             best_start_n;
   logic [4:0]             centre_tap;

   // Active lane word and the run bookkeeping for the tap being evaluated;
   // a later run replaces the best only when strictly longer, so ties keep the earlier run
   always_comb begin
      lane_word    = bus.rx_data[int'(ch)*SERI_FACTOR +: SERI_FACTOR];
      run_len      = stable ? (cur_len + 6'd1) : 6'd0;
      run_start    = (stable && (cur_len == 6'd0)) ? tap : cur_start;
      best_len_n   = (run_len > best_len) ? run_len : best_len;
      best_start_n = (run_len > best_len) ? run_start : best_start;
      centre_tap   = best_start + best_len[5:1];
   end

   // Alignment sequencer: sweep, centre, then bitslip until the training word appears
   always_ff @(posedge rx_clkdiv) begin
      if (reset) begin
         state        <= S_IDLE;
         ch           <= '0;
         tap          <= '0;
         cnt          <= '0;
         first_word   <= '0;
         stable       <= 1'b0;
         centred      <= 1'b0;
         cur_start    <= '0;
         cur_len      <= '0;
         best_start   <= '0;
         best_len     <= '0;
         check_cnt    <= '0;
         tap_load_r   <= '0;
         tap_value_r  <= '0;
         bitslip_r    <= '0;
         ch_aligned_r <= '0;
         busy_r       <= 1'b0;
         align_done_r <= 1'b0;
         align_fail_r <= 1'b0;
`ifdef LVDS_RX_ALIGN_EYE_STATUS_EN
         eye_width_r  <= '0;
`endif
      end else if (busy_r && !bus.idelayCtrl_rdy) begin
         // delay control lost: whatever was measured is void, restart from lane 0 tap 0
         state        <= S_WAIT_RDY;
         ch           <= '0;
         tap          <= '0;
         cnt          <= '0;
         centred      <= 1'b0;
         tap_load_r   <= '0;
         bitslip_r    <= '0;
         ch_aligned_r <= '0;
      end else begin
         tap_load_r <= '0;
         bitslip_r  <= '0;
         case (state)
            S_IDLE, S_DONE, S_FAIL: begin
               if (bus.start) begin
                  ch_aligned_r <= '0;
                  align_done_r <= 1'b0;
                  align_fail_r <= 1'b0;
                  busy_r       <= 1'b1;
                  ch           <= '0;
                  tap          <= '0;
                  state        <= S_WAIT_RDY;
`ifdef LVDS_RX_ALIGN_EYE_STATUS_EN
                  eye_width_r  <= '0;
`endif
               end
            end
            S_WAIT_RDY: begin
               if (bus.idelayCtrl_rdy) begin
                  tap        <= '0;
                  cnt        <= '0;
                  cur_start  <= '0;
                  cur_len    <= '0;
                  best_start <= '0;
                  best_len   <= '0;
                  centred    <= 1'b0;
                  state      <= S_SET_TAP;
               end
            end
            S_SET_TAP: begin
               tap_load_r[ch]               <= 1'b1;
               tap_value_r[int'(ch)*5 +: 5] <= tap;
               cnt                          <= '0;
               state                        <= S_SETTLE;
            end
            S_SETTLE: begin
               if (cnt == 8'(SETTLE_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= centred ? S_CHECK : S_SAMPLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_SAMPLE: begin
               if (cnt == 8'd0) begin
                  first_word <= lane_word;
                  stable     <= 1'b1;
               end else begin
                  stable <= stable && (lane_word == first_word);
               end
               if (cnt == 8'(SAMPLE_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= S_EVAL;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_EVAL: begin
               cur_len    <= run_len;
               cur_start  <= run_start;
               best_len   <= best_len_n;
               best_start <= best_start_n;
               if (tap == 5'd31) begin
                  if (best_len_n < 6'(MIN_EYE)) begin
                     align_fail_r <= 1'b1;
                     busy_r       <= 1'b0;
                     state        <= S_FAIL;
                  end else begin
                     state <= S_CENTER;
                  end
               end else begin
                  tap   <= tap + 5'd1;
                  state <= S_SET_TAP;
               end
            end
            S_CENTER: begin
               tap_load_r[ch]               <= 1'b1;
               tap_value_r[int'(ch)*5 +: 5] <= centre_tap;
               tap                          <= centre_tap;
               centred                      <= 1'b1;
               check_cnt                    <= '0;
               cnt                          <= '0;
               state                        <= S_SETTLE;
`ifdef LVDS_RX_ALIGN_EYE_STATUS_EN
               eye_width_r[int'(ch)*6 +: 6] <= best_len;
`endif
            end
            S_CHECK: begin
               if (lane_word == TRAIN_PATTERN) begin
                  ch_aligned_r[ch] <= 1'b1;
                  state            <= S_NEXT_CH;
               end else if (check_cnt == 4'(SERI_FACTOR - 1)) begin
                  // every word rotation has been tried
                  align_fail_r <= 1'b1;
                  busy_r       <= 1'b0;
                  state        <= S_FAIL;
               end else begin
                  check_cnt <= check_cnt + 4'd1;
                  state     <= S_SLIP;
               end
            end
            S_SLIP: begin
               bitslip_r[ch] <= 1'b1;
               cnt           <= '0;
               state         <= S_SLIP_WAIT;
            end
            S_SLIP_WAIT: begin
               if (cnt == 8'(SETTLE_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= S_CHECK;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_NEXT_CH: begin
               if (ch == CH_W'(CHANNELS - 1)) begin
                  align_done_r <= 1'b1;
                  busy_r       <= 1'b0;
                  state        <= S_DONE;
               end else begin
                  ch         <= ch + 1'b1;
                  tap        <= '0;
                  cur_start  <= '0;
                  cur_len    <= '0;
                  best_start <= '0;
                  best_len   <= '0;
                  centred    <= 1'b0;
                  state      <= S_SET_TAP;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.tap_load   = tap_load_r;
   assign bus.tap_value  = tap_value_r;
   assign bus.bitslip    = bitslip_r;
   assign bus.ch_aligned = ch_aligned_r;
   assign bus.busy       = busy_r;
   assign bus.align_done = align_done_r;
   assign bus.align_fail = align_fail_r;
`ifdef LVDS_RX_ALIGN_EYE_STATUS_EN
   assign bus.eye_width  = eye_width_r;
`endif

endmodule

// File: tb/tb_lvds_rx_align.sv
// tb/tb_lvds_rx_align.sv - directed bench for lvds_rx_align with a per-lane IDELAY/ISERDES model
module tb_lvds_rx_align;
   localparam int         CH     = 4;
   localparam int         SF     = 10;
   localparam int         SETTLE = 2;
   localparam int         SAMPLE = 2;
   localparam int         EYE    = 4;
   localparam logic [9:0] PAT    = 10'h3E0;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lvds_rx_align_if #(.CHANNELS(CH), .SERI_FACTOR(SF)) bus ();

   lvds_rx_align #(
      .CHANNELS(CH), .SERI_FACTOR(SF), .TRAIN_PATTERN(PAT),
      .SETTLE_CYCLES(SETTLE), .SAMPLE_CYCLES(SAMPLE), .MIN_EYE(EYE)
   ) dut (
      .rx_clkdiv(clk),
      .reset(reset),
      .bus(bus)
   );

   int          total;
   int          bad;
   logic [31:0] eye_mask [CH];
   int          off      [CH];
   logic        nomatch  [CH];
   logic [4:0]  cur_tap  [CH];
   int          slips    [CH];
   int          multi_hot;
   logic [31:0] cyc = 32'd0;
   logic        model_clr;

   function automatic logic [9:0] rotl(input logic [9:0] v, input int k);
      return (v << k) | (v >> (10 - k));
   endfunction

   function automatic logic [31:0] rng(input int lo, input int hi);
      logic [31:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   // delay line / deserialiser model: tracks loaded taps and cumulative bitslips
   always @(posedge clk) begin
      cyc <= cyc + 32'd1;
      if (model_clr) begin
         for (int i = 0; i < CH; i++) begin
            cur_tap[i] <= '0;
            slips[i]   <= 0;
         end
         multi_hot <= 0;
      end else begin
         if ($countones(bus.tap_load) > 1 || $countones(bus.bitslip) > 1)
            multi_hot <= multi_hot + 1;
         for (int i = 0; i < CH; i++) begin
            if (bus.tap_load[i]) cur_tap[i] <= bus.tap_value[i*5 +: 5];
            if (bus.bitslip[i])  slips[i]   <= slips[i] + 1;
         end
      end
   end

   // lane words: toggling outside the eye, rotated training word inside it
   always_comb begin : lane_model
      logic [9:0] w;
      bus.rx_data = '0;
      for (int i = 0; i < CH; i++) begin
         if (!eye_mask[i][cur_tap[i]])
            w = cyc[0] ? 10'h155 : 10'h2AA;
         else if (nomatch[i])
            w = 10'h001;
         else
            w = rotl(PAT, (off[i] + slips[i]) % SF);
         bus.rx_data[i*SF +: SF] = w;
      end
   end

   task automatic cyc_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_model();
      model_clr = 1'b1;
      @(negedge clk);
      model_clr = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (!bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic cfg_basic();
      eye_mask[0] = rng(10, 19);                 off[0] = 7;
      eye_mask[1] = rng(0, 2) | rng(28, 31);     off[1] = 0;
      eye_mask[2] = rng(2, 7) | rng(20, 25);     off[2] = 2;
      eye_mask[3] = 32'hFFFF_FFFF;               off[3] = 0;
      for (int i = 0; i < CH; i++) nomatch[i] = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b0;
      bus.idelayCtrl_rdy = 1'b1;
      model_clr = 1'b1;
      cfg_basic();
      cyc_n(3);
      total++; if (bus.tap_load !== 4'h0) begin bad++; $display("FAIL reset_tap_load: got %0h want 0", bus.tap_load); end
      total++; if (bus.tap_value !== 20'h0) begin bad++; $display("FAIL reset_tap_value: got %0h want 0", bus.tap_value); end
      total++; if (bus.bitslip !== 4'h0) begin bad++; $display("FAIL reset_bitslip: got %0h want 0", bus.bitslip); end
      total++; if (bus.ch_aligned !== 4'h0) begin bad++; $display("FAIL reset_ch_aligned: got %0h want 0", bus.ch_aligned); end
      total++; if ({bus.busy, bus.align_done, bus.align_fail} !== 3'b000) begin bad++; $display("FAIL reset_status: got %b want 000", {bus.busy, bus.align_done, bus.align_fail}); end
      reset = 1'b0;
      model_clr = 1'b0;
      cyc_n(2);
   endtask

   task automatic test_basic();
      bit ok;
      cfg_basic();
      clear_model();
      pulse_start();
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy_set: got %b want 1", bus.busy); end
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL basic_timeout: busy still 1 want 0"); end
      total++; if (bus.tap_value[4:0] !== 5'd15) begin bad++; $display("FAIL basic_tap0: got %0d want 15", bus.tap_value[4:0]); end
      total++; if (bus.tap_value[9:5] !== 5'd30) begin bad++; $display("FAIL basic_tap1_wrap_eye: got %0d want 30", bus.tap_value[9:5]); end
      total++; if (bus.tap_value[14:10] !== 5'd5) begin bad++; $display("FAIL basic_tap2_tie: got %0d want 5", bus.tap_value[14:10]); end
      total++; if (bus.tap_value[19:15] !== 5'd16) begin bad++; $display("FAIL basic_tap3_full: got %0d want 16", bus.tap_value[19:15]); end
      total++; if (slips[0] !== 3) begin bad++; $display("FAIL basic_slips0: got %0d want 3", slips[0]); end
      total++; if (slips[1] !== 0) begin bad++; $display("FAIL basic_slips1: got %0d want 0", slips[1]); end
      total++; if (slips[2] !== 8) begin bad++; $display("FAIL basic_slips2: got %0d want 8", slips[2]); end
      total++; if (slips[3] !== 0) begin bad++; $display("FAIL basic_slips3: got %0d want 0", slips[3]); end
      total++; if (bus.ch_aligned !== 4'hF) begin bad++; $display("FAIL basic_ch_aligned: got %0h want f", bus.ch_aligned); end
      total++; if ({bus.align_done, bus.align_fail} !== 2'b10) begin bad++; $display("FAIL basic_done_fail: got %b want 10", {bus.align_done, bus.align_fail}); end
      total++; if (multi_hot !== 0) begin bad++; $display("FAIL basic_one_lane_strobes: got %0d want 0", multi_hot); end
   endtask

   task automatic test_narrow_eye();
      bit ok;
      eye_mask[0] = rng(5, 7);
      off[0] = 0;
      clear_model();
      pulse_start();
      total++; if (bus.align_done !== 1'b0) begin bad++; $display("FAIL narrow_done_cleared: got %b want 0", bus.align_done); end
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL narrow_timeout: busy still 1 want 0"); end
      total++; if ({bus.align_fail, bus.align_done, bus.busy} !== 3'b100) begin bad++; $display("FAIL narrow_status: got %b want 100", {bus.align_fail, bus.align_done, bus.busy}); end
      total++; if (slips[0] !== 0) begin bad++; $display("FAIL narrow_slips: got %0d want 0", slips[0]); end
      total++; if (bus.ch_aligned !== 4'h0) begin bad++; $display("FAIL narrow_ch_aligned: got %0h want 0", bus.ch_aligned); end
   endtask

   task automatic test_never_match();
      bit ok;
      eye_mask[0] = rng(10, 19);
      nomatch[0] = 1'b1;
      clear_model();
      pulse_start();
      total++; if ({bus.align_fail, bus.busy} !== 2'b01) begin bad++; $display("FAIL nomatch_start_clears: got %b want 01", {bus.align_fail, bus.busy}); end
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL nomatch_timeout: busy still 1 want 0"); end
      total++; if (slips[0] !== 9) begin bad++; $display("FAIL nomatch_slips: got %0d want 9", slips[0]); end
      total++; if (bus.align_fail !== 1'b1) begin bad++; $display("FAIL nomatch_fail: got %b want 1", bus.align_fail); end
      total++; if (bus.tap_value[4:0] !== 5'd15) begin bad++; $display("FAIL nomatch_tap: got %0d want 15", bus.tap_value[4:0]); end
      total++; if (bus.ch_aligned !== 4'h0) begin bad++; $display("FAIL nomatch_ch_aligned: got %0h want 0", bus.ch_aligned); end
      nomatch[0] = 1'b0;
   endtask

   task automatic test_rdy_drop();
      bit ok;
      bit seen;
      int loads;
      cfg_basic();
      clear_model();
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (bus.tap_load[2]) begin
            seen = 1'b1;
            break;
         end
      end
      total++; if (!seen) begin bad++; $display("FAIL drop_lane2_reached: no lane 2 tap load want one"); end
      total++; if (bus.ch_aligned !== 4'b0011) begin bad++; $display("FAIL drop_before: got %0h want 3", bus.ch_aligned); end
      bus.idelayCtrl_rdy = 1'b0;
      @(negedge clk);
      total++; if ({bus.ch_aligned, bus.busy} !== 5'b0000_1) begin bad++; $display("FAIL drop_cleared: got %b want 00001", {bus.ch_aligned, bus.busy}); end
      loads = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.tap_load != 4'h0) loads++;
      end
      total++; if (loads !== 0) begin bad++; $display("FAIL drop_hold: got %0d loads want 0", loads); end
      bus.idelayCtrl_rdy = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.tap_load != 4'h0) begin
            seen = 1'b1;
            break;
         end
      end
      total++; if ({seen, bus.tap_load, bus.tap_value[4:0]} !== {1'b1, 4'b0001, 5'd0}) begin bad++; $display("FAIL drop_restart: got seen=%b load=%b tap=%0d want seen=1 load=0001 tap=0", seen, bus.tap_load, bus.tap_value[4:0]); end
      wait_idle(ok);
      total++; if ({ok, bus.ch_aligned, bus.align_done} !== 6'b1_1111_1) begin bad++; $display("FAIL drop_finish: got %b want 111111", {ok, bus.ch_aligned, bus.align_done}); end
      total++; if ({slips[0], slips[2]} !== {32'd3, 32'd8}) begin bad++; $display("FAIL drop_slips: got %0d,%0d want 3,8", slips[0], slips[2]); end
      total++; if (bus.tap_value !== {5'd16, 5'd5, 5'd30, 5'd15}) begin bad++; $display("FAIL drop_taps: got %0h want %0h", bus.tap_value, {5'd16, 5'd5, 5'd30, 5'd15}); end
   endtask

   task automatic test_reset_busy();
      bit seen;
      cfg_basic();
      clear_model();
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (bus.tap_load[0] && bus.tap_value[4:0] == 5'd5) begin
            seen = 1'b1;
            break;
         end
      end
      total++; if (!seen) begin bad++; $display("FAIL busy_tap5_reached: no tap 5 load want one"); end
      pulse_start();
      total++; if ({bus.busy, bus.align_done, bus.align_fail} !== 3'b100) begin bad++; $display("FAIL busy_start_ignored: got %b want 100", {bus.busy, bus.align_done, bus.align_fail}); end
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.tap_load != 4'h0) begin
            seen = 1'b1;
            break;
         end
      end
      total++; if ({seen, bus.tap_value[4:0]} !== {1'b1, 5'd6}) begin bad++; $display("FAIL busy_sweep_continues: got seen=%b tap=%0d want seen=1 tap=6", seen, bus.tap_value[4:0]); end
      cyc_n(2);
      reset = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      total++; if ({bus.tap_load, bus.bitslip, bus.ch_aligned} !== 12'h0) begin bad++; $display("FAIL midrun_reset_strobes: got %0h want 0", {bus.tap_load, bus.bitslip, bus.ch_aligned}); end
      total++; if (bus.tap_value !== 20'h0) begin bad++; $display("FAIL midrun_reset_tap_value: got %0h want 0", bus.tap_value); end
      total++; if ({bus.busy, bus.align_done, bus.align_fail} !== 3'b000) begin bad++; $display("FAIL midrun_reset_status: got %b want 000", {bus.busy, bus.align_done, bus.align_fail}); end
      reset = 1'b0;
      bus.start = 1'b0;
      cyc_n(4);
      total++; if ({bus.busy, bus.tap_load} !== 5'b0) begin bad++; $display("FAIL after_reset_idle: got %b want 00000", {bus.busy, bus.tap_load}); end
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_basic();
      test_narrow_eye();
      test_never_match();
      test_rdy_drop();
      test_reset_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
